ysyx_23060208_axil_arbiter: RTL
===============================

// Module: ysyx_23060208_axil_arbiter
// PURPOSE
//   N-master to 1-slave AXI-Lite arbiter for the NPC memory path.
//   Sits between the fetch/load-store masters (IFU, EXU) and a single shared SRAM/bus slave.
//   Replaces the current point-to-point isram/dsram wiring.
//   Carries one outstanding transaction at a time.
//   Arbitration mode is selectable: fixed priority or round-robin.
// PARAMETERS
//   N_MST       2   number of masters, >=1
//   AW          32  address width
//   DW          32  data width; strobe width is DW/8
//   RR_MODE     0   0: fixed priority (lowest index wins); 1: round-robin
//   GW          $clog2(N_MST), min 1   grant id width (localparam)
// PORTS
//   clk                    in   1          clock, all state on rising edge
//   rst                    in   1          asynchronous, active-high reset
//   m_awaddr / m_araddr    in   N*AW each  master i occupies slice [i*AW +: AW]
//   m_awvalid / m_arvalid  in   N each     per-master address valid
//   m_awready / m_arready  out  N each     per-master address ready
//   m_wdata / m_wstrb      in   N*DW, N*DW/8   write data / byte strobes
//   m_wvalid / m_wready    in / out   N    write data handshake
//   m_bresp / m_bvalid     out  N*2, N     write response to masters
//   m_bready               in   N          write response accept
//   m_rdata / m_rresp      out  N*DW, N*2  read data / response to masters
//   m_rvalid / m_rready    out / in   N    read data handshake
//   s_aw*, s_w*, s_ar*     out (ready in)  single-master copies of above, slave side
//   s_b*, s_r*             in (ready out)  slave responses
//   grant_id               out  GW         currently/last granted master
//   busy                   out  1          1 while state != IDLE
// BEHAVIOUR
//   Reset
//   - State goes to IDLE.
//   - Every valid/ready output is 0.
//   - m_*data and m_*resp outputs are 0.
//   - grant_id = 0, busy = 0.
//   - last_grant = N_MST-1, so round-robin starts at master 0.
//   - Reset mid-transaction abandons it; the slave is reset by the same rst.
//   Request and arbitration
//   - Master i requests when arvalid[i] | (awvalid[i] & wvalid[i]).
//   - In IDLE with any request, the winner is registered into grant_id.
//   - RR_MODE=0: the winner is the lowest requesting index.
//   - RR_MODE=1: the winner is the first requesting index after last_grant, wrapping N_MST-1 -> 0.
//   - Within the winner, a write has priority over a read. Next state is WR_A or RD_A.
//   - Arbitration costs exactly 1 cycle: a request at cycle t puts the slave valid at t+1.
//   FSM: IDLE -> RD_A -> RD_D -> IDLE
//   - RD_A: s_ar* = granted master's ar*, m_arready[g] = s_arready.
//     On s_arvalid & s_arready go to RD_D.
//   - RD_D: m_rvalid[g] = s_rvalid, m_rdata/m_rresp[g] = s_rdata/s_rresp, s_rready = m_rready[g].
//     On the handshake go to IDLE and set last_grant = g.
//   FSM: IDLE -> WR_A -> WR_B -> IDLE
//   - WR_A: aw and w are forwarded independently.
//     Per-channel done flags mask that channel's valid after its handshake.
//     Go to WR_B when both are done; the flags are cleared on entry to IDLE.
//   - WR_B: b channel is forwarded as in RD_D. On the handshake go to IDLE and set last_grant = g.
//   Masking and pass-through
//   - Non-granted masters see all ready/valid = 0 and data = 0.
//   - Slave-side valids are 0 in IDLE.
//   - Forwarding is combinational from the registered grant; no data registers.
//   - Responses (including SLVERR/DECERR) are forwarded unmodified.
//   - Backpressure holds the state and grant indefinitely; there is no timeout.
//   - A master dropping valid before its handshake is a protocol violation; behaviour is undefined.
//   - N_MST = 1 degenerates to a registered pass-through with a 1-cycle IDLE gap between transactions.
// TESTING
//   - Reset: rst=1 pulsed during RD_D -> all ready/valid outputs 0 on the same cycle, busy=0, next grant goes to master 0.
//   - Fixed priority (RR_MODE=0, N=2): m0 and m1 arvalid in the same cycle, slave returns 0x11 then 0x22
//     -> m0 gets rdata 0x11 first, m1 gets 0x22, m1_rvalid never 1 while grant_id=0.
//   - Round-robin (RR_MODE=1, N=3): all masters hold arvalid for 6 transactions -> grant_id sequence 0,1,2,0,1,2.
//   - Write split: m1 awvalid at t, wvalid at t+3, slave bresp=2'b10 -> s_wvalid at t+4, m1 bresp=2'b10, no bvalid to m0.
//   - Write-before-read: master 0 asserts arvalid plus awvalid/wvalid together -> write completes (B) before s_arvalid rises.
//   - Backpressure: m_rready low for 5 cycles with s_rvalid high -> s_rready low, state and grant_id held, completes on cycle 6.

Source files
------------

// File: rtl/ysyx_23060208_axil_arbiter_if.sv
// rtl/ysyx_23060208_axil_arbiter_if.sv - AXI-Lite bundle of N lanes, lane i at slice i
interface ysyx_23060208_axil_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N*AW-1:0]   awaddr;
    logic [N-1:0]      awvalid;
    logic [N-1:0]      awready;
    logic [N*DW-1:0]   wdata;
    logic [N*DW/8-1:0] wstrb;
    logic [N-1:0]      wvalid;
    logic [N-1:0]      wready;
    logic [N*2-1:0]    bresp;
    logic [N-1:0]      bvalid;
    logic [N-1:0]      bready;
    logic [N*AW-1:0]   araddr;
    logic [N-1:0]      arvalid;
    logic [N-1:0]      arready;
    logic [N*DW-1:0]   rdata;
    logic [N*2-1:0]    rresp;
    logic [N-1:0]      rvalid;
    logic [N-1:0]      rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ysyx_23060208_axil_arbiter.sv
// rtl/ysyx_23060208_axil_arbiter.sv - N-master to 1-slave AXI-Lite arbiter, one outstanding transaction
module ysyx_23060208_axil_arbiter #(
    parameter int N_MST    = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RR_MODE  = 0,
    localparam int GW      = (N_MST > 1) ? $clog2(N_MST) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_23060208_axil_arbiter_if.slave  m_if,
    ysyx_23060208_axil_arbiter_if.master s_if,
    output logic [GW-1:0]                grant_id_o,
    output logic                         busy_o
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    last_q, last_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;

    logic [N_MST-1:0] req;
    logic [GW-1:0]    winner;
    logic             found;
    int               idx;
    int               g;
    logic             aw_hs;
    logic             w_hs;

    // Round-robin scans starting one past the last completed grant.
    always_comb begin
        req    = m_if.arvalid | (m_if.awvalid & m_if.wvalid);
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_MST; k++) begin
            if (RR_MODE != 0) begin
                idx = int'(last_q) + 1 + k;
                if (idx >= N_MST) idx = idx - N_MST;
            end else begin
                idx = k;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        g         = int'(grant_q);
        aw_hs     = 1'b0;
        w_hs      = 1'b0;

        m_if.awready = '0;
        m_if.wready  = '0;
        m_if.bresp   = '0;
        m_if.bvalid  = '0;
        m_if.arready = '0;
        m_if.rdata   = '0;
        m_if.rresp   = '0;
        m_if.rvalid  = '0;

        s_if.awaddr  = '0;
        s_if.awvalid = 1'b0;
        s_if.wdata   = '0;
        s_if.wstrb   = '0;
        s_if.wvalid  = 1'b0;
        s_if.bready  = 1'b0;
        s_if.araddr  = '0;
        s_if.arvalid = 1'b0;
        s_if.rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = winner;
                    state_d = (m_if.awvalid[winner] & m_if.wvalid[winner]) ? WR_A : RD_A;
                end
            end
            RD_A: begin
                s_if.araddr     = m_if.araddr[g*AW +: AW];
                s_if.arvalid    = m_if.arvalid[g];
                m_if.arready[g] = s_if.arready;
                if (s_if.arvalid && s_if.arready) state_d = RD_D;
            end
            RD_D: begin
                m_if.rvalid[g]          = s_if.rvalid;
                m_if.rdata[g*DW +: DW]  = s_if.rdata;
                m_if.rresp[g*2 +: 2]    = s_if.rresp;
                s_if.rready             = m_if.rready[g];
                if (s_if.rvalid && s_if.rready) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            WR_A: begin
                // Each channel is masked once it has handshaken so it is not sent twice.
                s_if.awaddr     = m_if.awaddr[g*AW +: AW];
                s_if.awvalid    = m_if.awvalid[g] & ~aw_done_q;
                m_if.awready[g] = s_if.awready & ~aw_done_q;
                s_if.wdata      = m_if.wdata[g*DW +: DW];
                s_if.wstrb      = m_if.wstrb[g*(DW/8) +: DW/8];
                s_if.wvalid     = m_if.wvalid[g] & ~w_done_q;
                m_if.wready[g]  = s_if.wready & ~w_done_q;
                aw_hs           = s_if.awvalid & s_if.awready;
                w_hs            = s_if.wvalid & s_if.wready;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_B;
            end
            WR_B: begin
                m_if.bvalid[g]       = s_if.bvalid;
                m_if.bresp[g*2 +: 2] = s_if.bresp;
                s_if.bready          = m_if.bready[g];
                if (s_if.bvalid && s_if.bready) begin
                    state_d   = IDLE;
                    last_d    = grant_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(N_MST - 1);
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign grant_id_o = grant_q;
    assign busy_o     = (state_q != IDLE);

endmodule
